// File: rtl/ctu_jbus_rst_seq.sv
// ctu_jbus_rst_seq
//   Drives the jbus cluster header's cluster_cken, grst_l and gdbginit_l
//   inputs through an ordered bring-up: clock-enable ramp, held global reset,
//   then release. Also handles warm-reset and debug-init requests while
//   running, and an orderly shutdown that reasserts reset before gating the
//   clock. Every output is a flop, so the header sees glitch-free levels.
//
// Ports
//   gclk         in   global jbus clock, rising-edge active
//   arst         in   asynchronous active-high reset
//   cken_en      in   software enable for the jbus cluster (level)
//   wrst_req     in   warm reset request, sampled only in RUN (level)
//   dbg_req      in   debug-init request, sampled only in RUN (level)
//   cluster_cken out  cluster clock enable
//   grst_l       out  global reset, active-low
//   gdbginit_l   out  debug init, active-low
//   seq_busy     out  high in every state except IDLE and RUN
//   seq_done     out  one-cycle pulse on the cycle RUN is entered

module ctu_jbus_rst_seq #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned CKEN_DLY = 4,
    parameter int unsigned GRST_CYC = 16,
    parameter int unsigned DBG_CYC  = 8
) (
    input  logic gclk,
    input  logic arst,
    input  logic cken_en,
    input  logic wrst_req,
    input  logic dbg_req,
    output logic cluster_cken,
    output logic grst_l,
    output logic gdbginit_l,
    output logic seq_busy,
    output logic seq_done
);

    typedef enum logic [2:0] {
        StIdle,
        StCken,
        StGrst,
        StRun,
        StDbg,
        StQuies
    } state_e;

    // Phase lengths expressed as counter load values (N-1).
    localparam logic [CNT_W-1:0] CkenLoad = CNT_W'(CKEN_DLY - 1);
    localparam logic [CNT_W-1:0] GrstLoad = CNT_W'(GRST_CYC - 1);
    localparam logic [CNT_W-1:0] DbgLoad  = CNT_W'(DBG_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic cken_q, cken_d;
    logic grst_l_q, grst_l_d;
    logic dbg_l_q, dbg_l_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic cnt_zero;
    assign cnt_zero = (cnt_q == '0);

    // State register (includes the counter and the registered outputs).
    always_ff @(posedge gclk or posedge arst) begin
        if (arst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            cken_q   <= 1'b0;
            grst_l_q <= 1'b0;
            dbg_l_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cken_q   <= cken_d;
            grst_l_q <= grst_l_d;
            dbg_l_q  <= dbg_l_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_zero) ? cnt_q : cnt_q - CNT_W'(1);
        unique case (state_q)
            StIdle: begin
                if (cken_en) begin
                    state_d = StCken;
                    cnt_d   = CkenLoad;
                end
            end
            StCken: begin
                if (cnt_zero) begin
                    state_d = StGrst;
                    cnt_d   = GrstLoad;
                end
            end
            StGrst: begin
                if (cnt_zero) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // Warm reset wins over debug init when both are requested.
                if (wrst_req) begin
                    state_d = StGrst;
                    cnt_d   = GrstLoad;
                end else if (dbg_req) begin
                    state_d = StDbg;
                    cnt_d   = DbgLoad;
                end
            end
            StDbg: begin
                if (cnt_zero) begin
                    state_d = StRun;
                end
            end
            StQuies: begin
                // Always runs to completion; cken_en is ignored here.
                if (cnt_zero) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Dropping the enable overrides every other transition, including an
        // expiring counter, so reset is reasserted before the clock is gated.
        if (!cken_en && (state_q inside {StCken, StGrst, StRun, StDbg})) begin
            state_d = StQuies;
            cnt_d   = CkenLoad;
        end
    end

    // Output logic: decoded from the next state so outputs move on the same
    // edge as the state itself.
    always_comb begin
        cken_d   = 1'b0;
        grst_l_d = 1'b0;
        dbg_l_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = (state_d == StRun) && (state_q != StRun);
        unique case (state_d)
            StIdle: begin
            end
            StCken, StGrst, StQuies: begin
                cken_d = 1'b1;
                busy_d = 1'b1;
            end
            StRun: begin
                cken_d   = 1'b1;
                grst_l_d = 1'b1;
                dbg_l_d  = 1'b1;
            end
            StDbg: begin
                cken_d   = 1'b1;
                grst_l_d = 1'b1;
                busy_d   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign cluster_cken = cken_q;
    assign grst_l       = grst_l_q;
    assign gdbginit_l   = dbg_l_q;
    assign seq_busy     = busy_q;
    assign seq_done     = done_q;

endmodule

// File: tb/tb_ctu_jbus_rst_seq.sv
module tb_ctu_jbus_rst_seq;

    logic gclk = 1'b0;
    logic arst;
    logic cken_en;
    logic wrst_req;
    logic dbg_req;
    logic cluster_cken;
    logic grst_l;
    logic gdbginit_l;
    logic seq_busy;
    logic seq_done;

    int total = 0;
    int bad   = 0;

    ctu_jbus_rst_seq #(
        .CNT_W   (8),
        .CKEN_DLY(4),
        .GRST_CYC(16),
        .DBG_CYC (8)
    ) dut (
        .gclk        (gclk),
        .arst        (arst),
        .cken_en     (cken_en),
        .wrst_req    (wrst_req),
        .dbg_req     (dbg_req),
        .cluster_cken(cluster_cken),
        .grst_l      (grst_l),
        .gdbginit_l  (gdbginit_l),
        .seq_busy    (seq_busy),
        .seq_done    (seq_done)
    );

    always #5 gclk = ~gclk;

    // One record = inputs applied before an edge, expected outputs after it,
    // repeated for n consecutive edges.
    typedef struct {
        logic       ce;
        logic       wr;
        logic       db;
        logic [4:0] exp;  // {cken, grst_l, gdbginit_l, busy, done}
        int         n;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    localparam logic [4:0] OIdle = 5'b00000;
    localparam logic [4:0] OBusy = 5'b10010;  // CKEN / GRST / QUIES
    localparam logic [4:0] ORunD = 5'b11101;  // RUN entry with done
    localparam logic [4:0] ORun  = 5'b11100;
    localparam logic [4:0] ODbg  = 5'b11010;

    function automatic void add(logic ce, logic wr, logic db, logic [4:0] exp, int n,
                                string tag);
        vec_t v;
        v.ce = ce; v.wr = wr; v.db = db; v.exp = exp; v.n = n; v.tag = tag;
        vecs.push_back(v);
    endfunction

    function automatic logic [4:0] outs();
        return {cluster_cken, grst_l, gdbginit_l, seq_busy, seq_done};
    endfunction

    task automatic check(string tag, logic [4:0] exp);
        total++;
        if (outs() !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%b want=%b", tag, $time, outs(), exp);
        end
    endtask

    // Called at posedge+1; leaves time at posedge+1 afterwards.
    task automatic run_vecs();
        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                cken_en  = vecs[i].ce;
                wrst_req = vecs[i].wr;
                dbg_req  = vecs[i].db;
                @(posedge gclk);
                #1;
                check($sformatf("%s[%0d]", vecs[i].tag, k), vecs[i].exp);
            end
        end
        vecs.delete();
    endtask

    initial begin
        arst = 1'b1; cken_en = 1'b1; wrst_req = 1'b0; dbg_req = 1'b0;
        repeat (2) @(posedge gclk);
        #1;
        check("reset", OIdle);
        arst = 1'b0;

        // Bring-up: cken at edge 1, release and done at edge 21.
        add(1, 0, 0, OBusy, 4,  "up_cken");
        add(1, 0, 0, OBusy, 16, "up_grst");
        add(1, 0, 0, ORunD, 1,  "up_run");
        add(1, 0, 0, ORun,  2,  "run_hold");
        // 1-cycle warm reset: grst_l low exactly 16 cycles, cken stays 1.
        add(1, 1, 0, OBusy, 1,  "wrst_enter");
        add(1, 0, 0, OBusy, 15, "wrst_hold");
        add(1, 0, 0, ORunD, 1,  "wrst_run");
        add(1, 0, 0, ORun,  1,  "wrst_idle");
        // Both requests: warm reset path wins.
        add(1, 1, 1, OBusy, 1,  "both_enter");
        add(1, 0, 0, OBusy, 15, "both_hold");
        add(1, 0, 0, ORunD, 1,  "both_run");
        // Debug init: gdbginit_l low 8 cycles with grst_l high.
        add(1, 0, 1, ODbg,  1,  "dbg_enter");
        add(1, 0, 0, ODbg,  7,  "dbg_hold");
        add(1, 0, 0, ORunD, 1,  "dbg_run");
        add(1, 0, 0, ORun,  1,  "dbg_idle");
        // Enable dropped in GRST exactly when cnt==0: QUIES, never RUN.
        add(1, 1, 0, OBusy, 1,  "q_grst");
        add(1, 0, 0, OBusy, 15, "q_grst_hold");
        add(0, 0, 0, OBusy, 1,  "q_enter");
        add(1, 0, 0, OBusy, 3,  "q_hold");   // cken_en=1 ignored in QUIES
        add(1, 0, 0, OIdle, 1,  "q_idle");
        // IDLE re-launches.
        add(1, 0, 0, OBusy, 4,  "re_cken");
        add(1, 0, 0, OBusy, 16, "re_grst");
        add(1, 0, 0, ORunD, 1,  "re_run");
        // Enable drop in RUN overrides a simultaneous warm reset.
        add(0, 1, 0, OBusy, 1,  "run_q");
        add(0, 0, 0, OBusy, 3,  "run_q_hold");
        add(0, 0, 0, OIdle, 2,  "run_q_idle");
        // Relaunch and go into DBG for the arst test.
        add(1, 0, 0, OBusy, 20, "l2_ramp");
        add(1, 0, 0, ORunD, 1,  "l2_run");
        add(1, 0, 1, ODbg,  1,  "l2_dbg");
        add(1, 0, 0, ODbg,  3,  "l2_dbg_hold");
        run_vecs();

        // Asynchronous reset mid-DBG: outputs clear before any clock edge.
        #2 arst = 1'b1;
        #1 check("arst_async", OIdle);
        @(posedge gclk);
        #1 check("arst_held", OIdle);
        arst = 1'b0;

        add(1, 0, 0, OBusy, 4,  "rst_cken");
        add(1, 0, 0, OBusy, 16, "rst_grst");
        add(1, 0, 0, ORunD, 1,  "rst_run");
        add(1, 0, 0, ORun,  1,  "rst_idle");
        run_vecs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
